if_fetch_buffer: RTL and testbench
==================================

IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pc_i  input  32  current PC from PC register.
REQ-005 SHALL have port pc_stall_o  output  1  hold PC (drives PC-register stall input).
REQ-006 SHALL have port redirect_i  input  1  branch/jump/jalr taken; flush fetch path.
REQ-007 SHALL have port imem_req_o  output  1  instruction-memory request strobe, single cycle.
REQ-008 SHALL have port imem_addr_o  output  32  request address.
REQ-009 SHALL have port imem_rvalid_i  input  1  response valid, in order, latency >=1 cycle.
REQ-010 SHALL have port imem_rdata_i  input  32  response instruction word.
REQ-011 SHALL have port id_valid_o  output  1  queue head valid toward decode.
REQ-012 SHALL have port id_ready_i  input  1  decode accepts head.
REQ-013 SHALL have port id_pc_o  output  32  PC of head entry.
REQ-014 SHALL have port id_instr_o  output  32  instruction of head entry.

Function
REQ-015 SHALL implement FSM states IDLE (no outstanding request), WAIT (one outstanding), DROP (outstanding response to discard).
REQ-016 SHALL issue (imem_req_o=1, imem_addr_o=pc_i, latch pc_i) when in IDLE, redirect_i=0, queue count < DEPTH; next state WAIT.
REQ-017 SHALL assert pc_stall_o=0 in exactly the cycles a request issues or redirect_i=1; otherwise 1.
REQ-018 SHALL, in WAIT with imem_rvalid_i=1 and redirect_i=0, push {latched PC, imem_rdata_i} to the queue.
REQ-019 SHALL, in that same cycle, issue the next request and stay WAIT if count after push/pop < DEPTH; else go IDLE.
REQ-020 SHALL pop the head when id_valid_o and id_ready_i are both 1; id_valid_o=1 iff count>0.
REQ-021 SHALL allow simultaneous push and pop when full; count unchanged.
REQ-022 SHALL never push when full; full queue holds requests off (REQ-016).
REQ-023 SHALL, on redirect_i=1, empty the queue at that edge, issue no request, and discard any response arriving that cycle.
REQ-024 SHALL, on redirect_i=1 in WAIT without imem_rvalid_i, enter DROP; in DROP, first imem_rvalid_i is discarded, next state IDLE.
REQ-025 SHALL treat redirect_i in DROP as no further state change (still one response pending).
REQ-026 SHALL keep imem_addr_o equal to pc_i combinationally; only imem_req_o qualifies it.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, count 0, queue pointers 0, latched PC 0.
REQ-028 SHALL reset outputs to imem_req_o=0, id_valid_o=0, id_pc_o=0, id_instr_o=0, pc_stall_o=1.
REQ-029 SHALL ignore any response from a request outstanding when reset asserted (state IDLE after release).

Configuration
REQ-030 SHALL use macro FETCH_ALIGN_CHECK_EN; when defined, add output id_fault_o (1 bit) and, in issue conditions with pc_i[1:0]!=0, issue no memory request, push {pc_i, 32'h0000_0013} with fault=1, pc_stall_o=0.
REQ-031 SHALL, without FETCH_ALIGN_CHECK_EN, omit id_fault_o and request any pc_i unchanged.

Structure
REQ-032 SHALL place state enum, NOP constant 32'h0000_0013 and queue entry type (pc, instr, fault) in shared package fetch_pkg.
REQ-033 SHALL instantiate one sub-module fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count.

Verification
REQ-034 SHALL cover reset release, pc_i=0, 1-cycle latency, id_ready_i=1 -> requests at 0,4,8 every cycle after first; id_pc_o 0,4,8 in order.
REQ-035 SHALL cover id_ready_i=0, DEPTH=2 -> exactly 2 entries pushed, then imem_req_o=0 and pc_stall_o=1 until a pop.
REQ-036 SHALL cover redirect_i=1 in WAIT, response 3 cycles later -> response dropped, id_valid_o=0, next request at new pc_i after DROP.
REQ-037 SHALL cover redirect_i coincident with imem_rvalid_i -> data not pushed, queue empty next cycle, state IDLE.
REQ-038 SHALL cover rst=0 asserted mid-WAIT -> outputs at reset values immediately; late response ignored.
REQ-039 SHALL cover, with FETCH_ALIGN_CHECK_EN, pc_i=32'h0000_0006 -> no imem_req_o, head {6, 32'h0000_0013}, id_fault_o=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path types: FSM state encoding, canonical NOP and the queue entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; the pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  // Pointer, occupancy and storage updates; a push into a full queue is only taken alongside a pop.
  always_comb begin
    mem_d     = mem_q;
    do_pop_s  = pop_i && (count_q != '0);
    do_push_s = push_i && ((count_q != CW'(DEPTH)) || do_pop_s);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d = do_push_s ? (wptr_q + AW'(1)) : wptr_q;
      rptr_d = do_pop_s  ? (rptr_q + AW'(1)) : rptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (do_push_s) begin
        mem_d[wptr_q] = data_i;
      end else begin
        mem_d[wptr_q] = mem_q[wptr_q];
      end
    end
  end

  // State registers; storage is cleared too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch front end: one outstanding imem request, in-order response queue toward decode.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned PCs into faulting NOP entries instead of requests.
module if_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_stall_o,
  input  logic        redirect_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        id_fault_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam int EW = $bits(fetch_entry_t);
`else
  localparam int EW = $bits(fetch_entry_t) - 1;
`endif

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_s, cnt_after_s;
  logic          issue_s, push_s, fpush_s, pop_s, flush_s;
  logic          id_valid_s, space_s, misalign_s;
  logic [31:0]   push_pc_s, push_instr_s;
  logic [EW-1:0] push_bits_s, head_bits_s;

  assign id_valid_s = (count_s != '0);
  assign pop_s      = id_valid_s && id_ready_i;
  assign space_s    = (count_s < CW'(DEPTH));

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_s = pc_misaligned(pc_i);
`else
  assign misalign_s = 1'b0;
`endif

  // Next state and this cycle's issue / push / flush decisions.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    issue_s      = 1'b0;
    push_s       = 1'b0;
    fpush_s      = 1'b0;
    flush_s      = 1'b0;
    push_pc_s    = pc_q;
    push_instr_s = imem_rdata_i;
    cnt_after_s  = count_s + CW'(1) - CW'(pop_s);
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          flush_s = 1'b1;
        end else if (space_s && misalign_s) begin
          fpush_s      = 1'b1;
          push_s       = 1'b1;
          push_pc_s    = pc_i;
          push_instr_s = NOP_INSTR;
        end else if (space_s) begin
          issue_s = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          flush_s = 1'b1;
          state_d = imem_rvalid_i ? ST_IDLE : ST_DROP;
        end else if (imem_rvalid_i) begin
          push_s = 1'b1;
          // A misaligned next PC falls back to IDLE, which emits the fault entry.
          if ((cnt_after_s < CW'(DEPTH)) && !misalign_s) begin
            issue_s = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        flush_s = redirect_i;
        state_d = imem_rvalid_i ? ST_IDLE : ST_DROP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (issue_s) begin
      pc_d = pc_i;
    end else begin
      pc_d = pc_q;
    end
  end

  // FSM state and the PC of the request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  fetch_entry_t head_s;
  assign push_bits_s = {push_pc_s, push_instr_s, fpush_s};
  assign head_s      = head_bits_s;
  assign id_pc_o     = head_s.pc;
  assign id_instr_o  = head_s.instr;
  assign id_fault_o  = head_s.fault;
`else
  assign push_bits_s = {push_pc_s, push_instr_s};
  assign id_pc_o     = head_bits_s[63:32];
  assign id_instr_o  = head_bits_s[31:0];
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (push_bits_s),
    .data_o  (head_bits_s),
    .count_o (count_s)
  );

  // Request and stall are gated by reset so they hold their idle values while rst is low.
  assign imem_addr_o = pc_i;
  assign imem_req_o  = issue_s & rst;
  assign pc_stall_o  = ~(rst & (issue_s | fpush_s | redirect_i));
  assign id_valid_o  = id_valid_s;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer with a queue-level reference model and a latency-driven imem model.
module tb_if_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_stall_o;
  logic        redirect_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        id_fault_o;
`endif

  if_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_stall_o    (pc_stall_o),
    .redirect_i    (redirect_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .id_fault_o    (id_fault_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  ent_t        mq[$];
  rsp_t        pend[$];
  bit          outst;
  bit          drop;
  logic [31:0] opc;
  logic [31:0] pc_model;
  logic [31:0] req_log[$];
  logic [31:0] req_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'h1234_0000;
  endfunction

  function automatic bit bad_pc(input logic [31:0] p);
`ifdef FETCH_ALIGN_CHECK_EN
    return (p[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    else return 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    pop_pc.delete();
    pop_instr.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the model, advance the model.
  task automatic step(input bit rstn, input bit redir, input logic [31:0] tgt, input bit rdy);
    bit          e_req, e_fp, e_valid, e_pop, rv, push_rsp;
    logic [31:0] rd;
    int          after;
    ent_t        e;
    @(negedge clk);
    cyc++;
    rst        = rstn;
    redirect_i = redir;
    id_ready_i = rdy;
    pc_i       = pc_model;
    rv = 1'b0;
    rd = 32'h0000_0000;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rd = word_at(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    #1;
    e_req    = 1'b0;
    e_fp     = 1'b0;
    push_rsp = 1'b0;
    e_valid  = rstn && (mq.size() > 0);
    chkb("id_valid", id_valid_o, e_valid);
    if (!rstn) begin
      chk("rst_id_pc", id_pc_o, 32'h0000_0000);
      chk("rst_id_instr", id_instr_o, 32'h0000_0000);
    end else if (e_valid) begin
      chk("id_pc", id_pc_o, mq[0].pc);
      chk("id_instr", id_instr_o, mq[0].instr);
`ifdef FETCH_ALIGN_CHECK_EN
      chkb("id_fault", id_fault_o, mq[0].fault);
`endif
    end
    if (!rstn) begin
      mq.delete();
      outst = 1'b0;
      drop  = 1'b0;
      opc   = 32'h0000_0000;
    end else begin
      e_pop = e_valid && rdy;
      if (redir) begin
        mq.delete();
        if (outst) begin
          if (rv) begin
            outst = 1'b0;
            drop  = 1'b0;
          end else begin
            drop = 1'b1;
          end
        end
      end else if (outst) begin
        if (rv) begin
          outst = 1'b0;
          if (drop) begin
            drop = 1'b0;
          end else begin
            push_rsp = 1'b1;
            after = mq.size() + 1 - int'(e_pop);
            e_req = (after < DEPTH) && !bad_pc(pc_model);
          end
        end
      end else if (mq.size() < DEPTH) begin
        if (bad_pc(pc_model)) e_fp = 1'b1;
        else e_req = 1'b1;
      end
      if (!redir && e_pop) void'(mq.pop_front());
      if (push_rsp) begin
        e.pc = opc; e.instr = rd; e.fault = 1'b0;
        mq.push_back(e);
      end
      if (e_fp) begin
        e.pc = pc_model; e.instr = NOP_INSTR; e.fault = 1'b1;
        mq.push_back(e);
      end
      if (e_req) begin
        outst = 1'b1;
        opc   = pc_model;
        pend.push_back('{addr: pc_model, due: cyc + lat});
      end
    end
    chkb("imem_req", imem_req_o, e_req);
    chkb("pc_stall", pc_stall_o, !(rstn && (e_req || e_fp || redir)));
    chk("imem_addr", imem_addr_o, pc_model);
    if (imem_req_o) begin
      req_log.push_back(imem_addr_o);
      req_cyc.push_back(32'(cyc));
    end
    if (id_valid_o && rdy) begin
      pop_pc.push_back(id_pc_o);
      pop_instr.push_back(id_instr_o);
    end
    if (rstn && redir) pc_model = tgt;
    else if (rstn && (e_req || e_fp)) pc_model = pc_model + 32'd4;
  endtask

  task automatic do_reset(input logic [31:0] new_pc);
    pc_model = new_pc;
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; pc_i = 32'h0; redirect_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0; id_ready_i = 1'b0;
    outst = 1'b0; drop = 1'b0; opc = 32'h0; pc_model = 32'h0;

    // Reset values
    do_reset(32'h0000_0000);
    chkb("rst_req_lit", imem_req_o, 1'b0);
    chkb("rst_stall_lit", pc_stall_o, 1'b1);
    chkb("rst_valid_lit", id_valid_o, 1'b0);

    // Streaming from pc 0 with 1-cycle memory and decode always ready
    lat = 1;
    clear_logs();
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("s1_req0", qat(req_log, 0), 32'h0000_0000);
    chk("s1_req1", qat(req_log, 1), 32'h0000_0004);
    chk("s1_req2", qat(req_log, 2), 32'h0000_0008);
    chk("s1_b2b_a", qat(req_cyc, 1) - qat(req_cyc, 0), 32'd1);
    chk("s1_b2b_b", qat(req_cyc, 2) - qat(req_cyc, 1), 32'd1);
    chk("s1_pop0", qat(pop_pc, 0), 32'h0000_0000);
    chk("s1_pop1", qat(pop_pc, 1), 32'h0000_0004);
    chk("s1_pop2", qat(pop_pc, 2), 32'h0000_0008);
    chk("s1_instr0", qat(pop_instr, 0), 32'h1234_0000);

    // Decode stalled: queue fills to DEPTH and requests stop until a pop
    do_reset(32'h0000_0100);
    clear_logs();
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("s2_nreq", 32'(req_log.size()), 32'd2);
    chk("s2_req1", qat(req_log, 1), 32'h0000_0104);
    chkb("s2_full_req", imem_req_o, 1'b0);
    chkb("s2_full_stall", pc_stall_o, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chkb("s2_popcyc_req", imem_req_o, 1'b0);
    chk("s2_popped", qat(pop_pc, 0), 32'h0000_0100);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chkb("s2_resume_req", imem_req_o, 1'b1);
    chk("s2_resume_addr", imem_addr_o, 32'h0000_0108);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect while waiting; the late response is dropped
    lat = 3;
    do_reset(32'h0000_0200);
    clear_logs();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chkb("s3_drop_stall", pc_stall_o, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chkb("s3_drop_valid", id_valid_o, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chkb("s3_new_req", imem_req_o, 1'b1);
    chk("s3_new_addr", imem_addr_o, 32'h0000_0300);
    chk("s3_nreq", 32'(req_log.size()), 32'd2);
    chk("s3_npop", 32'(pop_pc.size()), 32'd0);

    // Redirect coincident with the response
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0400, 1'b1);
    chkb("s4_redir_stall", pc_stall_o, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chkb("s4_empty", id_valid_o, 1'b0);
    chkb("s4_idle_req", imem_req_o, 1'b1);
    chk("s4_idle_addr", imem_addr_o, 32'h0000_0400);

    // Reset asserted mid-wait; the response lands during reset
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chkb("s5_req", imem_req_o, 1'b0);
    chkb("s5_stall", pc_stall_o, 1'b1);
    chkb("s5_valid", id_valid_o, 1'b0);
    chk("s5_pc", id_pc_o, 32'h0000_0000);
    chk("s5_instr", id_instr_o, 32'h0000_0000);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    clear_logs();
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("s5_first_req", qat(req_log, 0), 32'h0000_0404);
    chk("s5_pop_pc", qat(pop_pc, 0), 32'h0000_0404);
    chk("s5_pop_instr", qat(pop_instr, 0), 32'h1234_0404);

    // Mixed traffic: 2-cycle memory, intermittent ready, two redirects
    lat = 2;
    do_reset(32'h0000_1000);
    for (int i = 0; i < 24; i++) begin
      if (i == 10) step(1'b1, 1'b1, 32'h0000_2000, (i % 3) != 0);
      else if (i == 17) step(1'b1, 1'b1, 32'h0000_3000, (i % 3) != 0);
      else step(1'b1, 1'b0, 32'h0, (i % 3) != 0);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned PC becomes a faulting NOP entry with no memory request
    lat = 1;
    do_reset(32'h0000_0006);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chkb("s6_noreq", imem_req_o, 1'b0);
    chkb("s6_advance", pc_stall_o, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chkb("s6_valid", id_valid_o, 1'b1);
    chk("s6_pc", id_pc_o, 32'h0000_0006);
    chk("s6_instr", id_instr_o, 32'h0000_0013);
    chkb("s6_fault", id_fault_o, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
